// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-latch enable/flush and PC enable for an N-stage pipeline.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int NSTAGES  = 5,
    parameter int BR_STAGE = 3,
    parameter int REGW     = 5
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                ihit,
    input  logic                dhit,
    input  logic                dmemREN,
    input  logic                dmemWEN,
    input  logic                halt,
    input  logic                branching,
    input  logic                jumping,
    input  logic                ex_load,
    input  logic [REGW-1:0]     ex_rd,
    input  logic [REGW-1:0]     id_rs,
    input  logic [REGW-1:0]     id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    output logic                pc_en,
    output logic [NSTAGES-2:0]  en,
    output logic [NSTAGES-2:0]  flush,
    output logic                halted
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         flush_events
`endif
);

    localparam int L = NSTAGES - 1;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FLUSHPEND = 2'd1,
        HALTED    = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             mem_busy_s;
    logic             redirect_s;
    logic             lu_hazard_s;
    logic             rule4_s;
    logic             pc_en_s;
    logic             halted_s;
    logic [L-1:0]     en_s;
    logic [L-1:0]     flush_s;

    // Hazard conditions derived from the raw datapath inputs
    always_comb begin
        mem_busy_s  = (dmemREN | dmemWEN) & ~dhit;
        redirect_s  = branching | jumping;
        lu_hazard_s = ex_load & (ex_rd != {REGW{1'b0}}) &
                      ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
    end

    // Prioritised next-state and enable/flush decode
    always_comb begin
        state_next_s = state_r;
        en_s         = {L{1'b0}};
        flush_s      = {L{1'b0}};
        pc_en_s      = 1'b0;
        halted_s     = 1'b0;
        rule4_s      = 1'b0;
        if (!nRST) begin
            // Latches hold bubbles while the pipeline is being reset
            flush_s = {L{1'b1}};
        end else begin
            case (state_r)
                HALTED: begin
                    halted_s = 1'b1;
                end
                RUN, FLUSHPEND: begin
                    if (mem_busy_s) begin
                        // A redirect seen during a memory wait is remembered and applied later
                        if ((state_r == RUN) && redirect_s) begin
                            state_next_s = FLUSHPEND;
                        end else begin
                            state_next_s = state_r;
                        end
                    end else if (halt) begin
                        en_s = {L{1'b1}};
                        for (int i = 0; i < L - 1; i++) begin
                            flush_s[i] = 1'b1;
                        end
                        state_next_s = HALTED;
                    end else if ((state_r == FLUSHPEND) || redirect_s) begin
                        en_s = {L{1'b1}};
                        for (int i = 0; i < BR_STAGE; i++) begin
                            flush_s[i] = 1'b1;
                        end
                        pc_en_s      = 1'b1;
                        rule4_s      = 1'b1;
                        state_next_s = RUN;
                    end else if (lu_hazard_s) begin
                        en_s       = {L{1'b1}};
                        en_s[0]    = 1'b0;
                        flush_s[1] = 1'b1;
                    end else if (!ihit) begin
                        en_s       = {L{1'b1}};
                        flush_s[0] = 1'b1;
                    end else begin
                        en_s    = {L{1'b1}};
                        pc_en_s = 1'b1;
                    end
                end
                default: begin
                    state_next_s = RUN;
                end
            endcase
        end
    end

    // Controller state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] flush_events_r;

    // Stall and redirect-flush event counters, wrapping naturally at 2^32
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles_r <= 32'd0;
            flush_events_r <= 32'd0;
        end else begin
            if ((state_r != HALTED) && !pc_en_s) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end
            if (rule4_s) begin
                flush_events_r <= flush_events_r + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign flush_events = flush_events_r;
`endif

    assign pc_en  = pc_en_s;
    assign en     = en_s;
    assign flush  = flush_s;
    assign halted = halted_s;

endmodule
